// File: rtl/ram_byte_lane_if.sv
// Request/response bus for the byte-lane RAM: valid/ready request, one-cycle response pulse.
interface ram_byte_lane_if #(
   parameter int WIDTH_ADDRESS = 20
);
   logic                     request_valid;
   logic                     request_ready;
   logic                     request_write;
   logic                     request_word;
   logic [WIDTH_ADDRESS-1:0] request_address;
   logic [15:0]              write_data;
   logic                     response_valid;
   logic [15:0]              read_data;

   modport master (
      output request_valid, request_write, request_word, request_address, write_data,
      input  request_ready, response_valid, read_data
   );

   modport slave (
      input  request_valid, request_write, request_word, request_address, write_data,
      output request_ready, response_valid, read_data
   );
endinterface

// File: rtl/ram_byte_lane.sv
// Single-port little-endian 16-bit RAM as two byte banks, 8086-style byte/word access.
// Odd-address word accesses take two internal cycles (IDLE -> SPLIT).
module ram_byte_lane #(
   parameter int WIDTH_ADDRESS = 20,
   parameter int DEPTH_WORDS   = 1024
) (
   input logic             clock,
   input logic             reset,
   ram_byte_lane_if.slave  bus
);
   localparam int K = $clog2(DEPTH_WORDS);

   typedef enum logic {IDLE, SPLIT} state_t;

   state_t         state, state_next;
   logic           ready_en;
   logic           ready;
   logic           accept;
   logic [K-1:0]   word_a;
   logic           lane_a;
   logic           is_split;

   // second-half context captured at accept so bus changes during SPLIT are ignored
   logic [K-1:0]   split_word;
   logic           split_write;
   logic [7:0]     split_hi;
   logic [7:0]     split_lo;

   logic [7:0]     lane0 [DEPTH_WORDS];
   logic [7:0]     lane1 [DEPTH_WORDS];

   assign word_a   = bus.request_address[K:1];
   assign lane_a   = bus.request_address[0];
   assign is_split = bus.request_word & lane_a;

   assign bus.request_ready = ready;

   // state register; ready_en keeps the port closed until the first edge after reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ready_en <= 1'b0;
      end else begin
         state    <= state_next;
         ready_en <= 1'b1;
      end
   end

   // next-state and handshake decode
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            ready  = ready_en;
            accept = bus.request_valid & ready_en;
            if (accept && is_split) state_next = SPLIT;
         end
         SPLIT: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // response pulse, read data and split context
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.response_valid <= 1'b0;
         bus.read_data      <= '0;
         split_word         <= '0;
         split_write        <= 1'b0;
         split_hi           <= '0;
         split_lo           <= '0;
      end else begin
         bus.response_valid <= 1'b0;
         if (state == SPLIT) begin
            bus.response_valid <= 1'b1;
            if (!split_write) bus.read_data <= {lane0[split_word], split_lo};
         end else if (accept) begin
            split_word  <= word_a + K'(1);
            split_write <= bus.request_write;
            split_hi    <= bus.write_data[15:8];
            split_lo    <= lane1[word_a];
            if (!is_split) begin
               bus.response_valid <= 1'b1;
               if (!bus.request_write) begin
                  if (!bus.request_word)
                     bus.read_data <= {8'h00, lane_a ? lane1[word_a] : lane0[word_a]};
                  else
                     bus.read_data <= {lane1[word_a], lane0[word_a]};
               end
            end
         end
      end
   end

   // memory banks; contents survive reset, and a reset during SPLIT drops the second half
   always_ff @(posedge clock) begin
      if (state == SPLIT) begin
         if (split_write) lane0[split_word] <= split_hi;
      end else if (accept && bus.request_write) begin
         if (bus.request_word && !lane_a) begin
            lane0[word_a] <= bus.write_data[7:0];
            lane1[word_a] <= bus.write_data[15:8];
         end else if (lane_a) begin
            lane1[word_a] <= bus.write_data[7:0];
         end else begin
            lane0[word_a] <= bus.write_data[7:0];
         end
      end
   end
endmodule
